// File: rtl/timer_bcd_multi_down_counter.sv
// N-digit synchronous BCD down-counter with parallel load, wrap/hold at zero,
// a done pulse on reaching zero and a borrow pulse for steps taken at zero.
module timer_bcd_multi_down_counter #(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  enable,
    output logic [4*DIGITS-1:0]   bcd_number,
    output logic                  zero,
    output logic                  done,
    output logic                  borrow_out
);
    localparam int W = 4 * DIGITS;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        logic [3:0] r;
        if (d > 4'd9) begin
            r = 4'd9;
        end else begin
            r = d;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = {W{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = clamp_digit(v[4*i +: 4]);
        end
        return r;
    endfunction

    // Ripple a single borrow from the LSD upward; a 0 digit under borrow becomes 9.
    function automatic logic [W-1:0] decrement_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        logic [3:0]   d;
        r = {W{1'b0}};
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (!b) begin
                r[4*i +: 4] = d;
            end else if (d == 4'd0) begin
                r[4*i +: 4] = 4'd9;
            end else begin
                r[4*i +: 4] = d - 4'd1;
                b = 1'b0;
            end
        end
        return r;
    endfunction

    logic [W-1:0] count_r;
    logic         zero_r;
    logic         done_r;
    logic         borrow_r;

    logic [W-1:0] next_count_s;
    logic         next_done_s;
    logic         next_borrow_s;
    logic         count_zero_s;

    // Next-state selection in priority order: clear, load, enabled step, idle.
    always_comb begin
        next_count_s  = count_r;
        next_done_s   = 1'b0;
        next_borrow_s = 1'b0;
        count_zero_s  = (count_r == {W{1'b0}});
        if (!clear) begin
            next_count_s = {W{1'b0}};
        end else if (load) begin
            next_count_s = clamp_bcd(load_value);
        end else if (enable) begin
            if (count_zero_s) begin
                next_borrow_s = 1'b1;
                if (WRAP) begin
                    next_count_s = {DIGITS{4'd9}};
                end else begin
                    next_count_s = {W{1'b0}};
                end
            end else begin
                next_count_s = decrement_bcd(count_r);
                next_done_s  = (decrement_bcd(count_r) == {W{1'b0}});
            end
        end else begin
            next_count_s = count_r;
        end
    end

    // State and status registers; zero is registered alongside the count it describes.
    always_ff @(posedge clk) begin
        count_r  <= next_count_s;
        zero_r   <= (next_count_s == {W{1'b0}});
        done_r   <= next_done_s;
        borrow_r <= next_borrow_s;
    end

    assign bcd_number = count_r;
    assign zero       = zero_r;
    assign done       = done_r;
    assign borrow_out = borrow_r;

endmodule

// File: tb/tb_timer_bcd_multi_down_counter.sv
// Directed and randomised checks of the BCD down-counter: two 2-digit instances
// (wrap and hold) driven together, plus a 4-digit instance against a decimal model.
module tb_timer_bcd_multi_down_counter;
    logic        clk;
    logic        clear, load, enable;
    logic [7:0]  lv;
    logic [7:0]  bcd_w1, bcd_w0;
    logic        zero_w1, done_w1, borrow_w1;
    logic        zero_w0, done_w0, borrow_w0;

    logic        clear4, load4, enable4;
    logic [15:0] lv4;
    logic [15:0] bcd4;
    logic        zero4, done4, borrow4;

    int errors = 0;
    int checks = 0;

    timer_bcd_multi_down_counter #(.DIGITS(2), .WRAP(1'b1)) dut_w1 (
        .clk(clk), .clear(clear), .load(load), .load_value(lv), .enable(enable),
        .bcd_number(bcd_w1), .zero(zero_w1), .done(done_w1), .borrow_out(borrow_w1));

    timer_bcd_multi_down_counter #(.DIGITS(2), .WRAP(1'b0)) dut_w0 (
        .clk(clk), .clear(clear), .load(load), .load_value(lv), .enable(enable),
        .bcd_number(bcd_w0), .zero(zero_w0), .done(done_w0), .borrow_out(borrow_w0));

    timer_bcd_multi_down_counter #(.DIGITS(4), .WRAP(1'b1)) dut_d4 (
        .clk(clk), .clear(clear4), .load(load4), .load_value(lv4), .enable(enable4),
        .bcd_number(bcd4), .zero(zero4), .done(done4), .borrow_out(borrow4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int clamp_val(input logic [15:0] v);
        int s, mul, d;
        s = 0;
        mul = 1;
        for (int i = 0; i < 4; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            s += d * mul;
            mul *= 10;
        end
        return s;
    endfunction

    task automatic chk2(input string tag, input logic [7:0] e1, input logic [7:0] e0,
                        input logic d1, input logic d0, input logic b1, input logic b0);
        chk({tag, "_w1_bcd"}, {8'h00, bcd_w1}, {8'h00, e1});
        chk({tag, "_w0_bcd"}, {8'h00, bcd_w0}, {8'h00, e0});
        chk({tag, "_w1_zero"}, {15'h0, zero_w1}, {15'h0, (e1 == 8'h00)});
        chk({tag, "_w0_zero"}, {15'h0, zero_w0}, {15'h0, (e0 == 8'h00)});
        chk({tag, "_w1_done"}, {15'h0, done_w1}, {15'h0, d1});
        chk({tag, "_w0_done"}, {15'h0, done_w0}, {15'h0, d0});
        chk({tag, "_w1_borrow"}, {15'h0, borrow_w1}, {15'h0, b1});
        chk({tag, "_w0_borrow"}, {15'h0, borrow_w0}, {15'h0, b0});
    endtask

    initial begin
        int m, r;
        logic ed, eb;
        logic [7:0] e;
        clear = 1'b0; load = 1'b0; enable = 1'b0; lv = 8'h00;
        clear4 = 1'b0; load4 = 1'b0; enable4 = 1'b0; lv4 = 16'h0000;
        step();
        chk2("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load 25 then count all the way down to 00
        clear = 1'b1; load = 1'b1; lv = 8'h25;
        step();
        chk2("load25", 8'h25, 8'h25, 1'b0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; enable = 1'b1;
        for (int v = 24; v >= 0; v--) begin
            step();
            e = to_bcd(v)[7:0];
            chk2("count", e, e, (v == 0), (v == 0), 1'b0, 1'b0);
        end
        step();
        chk2("atzero1", 8'h99, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk2("atzero2", 8'h98, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        enable = 1'b0;
        step();
        chk2("idle", 8'h98, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Clear mid-count, and clear dropping a done that would otherwise fire
        load = 1'b1; lv = 8'h25;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        chk2("mid24", 8'h24, 8'h24, 1'b0, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        step();
        chk2("midclr", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        clear = 1'b1; load = 1'b1; enable = 1'b0; lv = 8'h01;
        step();
        clear = 1'b0; load = 1'b0; enable = 1'b1;
        step();
        chk2("clrdone", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Clamping loads and load-over-enable
        clear = 1'b1; load = 1'b1; enable = 1'b0; lv = 8'h3C;
        step();
        chk2("clamp3C", 8'h39, 8'h39, 1'b0, 1'b0, 1'b0, 1'b0);
        lv = 8'hF5;
        step();
        chk2("clampF5", 8'h95, 8'h95, 1'b0, 1'b0, 1'b0, 1'b0);
        lv = 8'hAB;
        step();
        chk2("clampAB", 8'h99, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
        lv = 8'h57; enable = 1'b1;
        step();
        chk2("loadwin", 8'h57, 8'h57, 1'b0, 1'b0, 1'b0, 1'b0);

        // Enable toggling from 10
        lv = 8'h10; enable = 1'b0;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        chk2("tog09", 8'h09, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        step();
        chk2("hold09", 8'h09, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        step();
        chk2("tog08", 8'h08, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        step();
        chk2("hold08", 8'h08, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);

        // Four-digit instance: directed borrow chain then random against a decimal model
        chk("d4_reset", bcd4, 16'h0000);
        chk("d4_reset_zero", {15'h0, zero4}, 16'h0001);
        clear4 = 1'b1; load4 = 1'b1; lv4 = 16'h1000;
        step();
        chk("d4_load", bcd4, 16'h1000);
        load4 = 1'b0; enable4 = 1'b1;
        step();
        chk("d4_step", bcd4, 16'h0999);
        chk("d4_step_done", {15'h0, done4}, 16'h0000);

        m = 999;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            clear4  = (r < 4) ? 1'b0 : 1'b1;
            load4   = (r >= 4 && r < 14) ? 1'b1 : 1'b0;
            enable4 = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            lv4 = ($urandom_range(0, 1) != 0) ? 16'($urandom)
                                              : {12'h000, 4'($urandom_range(0, 15))};
            ed = 1'b0;
            eb = 1'b0;
            if (!clear4) begin
                m = 0;
            end else if (load4) begin
                m = clamp_val(lv4);
            end else if (enable4) begin
                if (m != 0) begin
                    m--;
                    ed = (m == 0);
                end else begin
                    eb = 1'b1;
                    m = 9999;
                end
            end
            step();
            chk("rnd_bcd", bcd4, to_bcd(m));
            chk("rnd_zero", {15'h0, zero4}, {15'h0, (m == 0)});
            chk("rnd_done", {15'h0, done4}, {15'h0, ed});
            chk("rnd_borrow", {15'h0, borrow4}, {15'h0, eb});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
